// File: rtl/eth_phy_10g_pkg.sv
// eth_phy_10g_pkg
// Shared definitions for the 10G PHY link controller:
//   - link_state_t : FSM state encoding, also driven onto the link_state port
//   - default parameter constants
//   - sat_sum_width / timer_width : width helpers for counters and the timer
package eth_phy_10g_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SERDES_RST  = 3'd1,
    WAIT_LOCK   = 3'd2,
    WAIT_STABLE = 3'd3,
    LINK_UP     = 3'd4,
    PRBS        = 3'd5
  } link_state_t;

  localparam int DEF_RESET_CYCLES  = 64;
  localparam int DEF_LOCK_TIMEOUT  = 65535;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_CNT_WIDTH     = 16;

  // A saturating add needs one extra bit to catch the carry out of the
  // counter. The increment is assumed to be no wider than the counter.
  function automatic int sat_sum_width(input int cnt_width);
    return cnt_width + 1;
  endfunction

  // The shared down-counter must hold (largest duration - 1). It is never
  // narrower than one bit, even when every duration is 1.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/eth_sat_counter.sv
// eth_sat_counter
// Saturating accumulator: adds inc_val whenever inc_en is high and sticks at
// all-ones rather than wrapping. clear has priority over the increment.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   clear     : synchronous clear to 0
//   inc_en    : add inc_val this cycle
//   inc_val   : increment amount (INC_WIDTH bits, INC_WIDTH <= WIDTH)
//   count     : current value (WIDTH bits)
module eth_sat_counter
  import eth_phy_10g_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int INC_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 inc_en,
  input  logic [INC_WIDTH-1:0] inc_val,
  output logic [WIDTH-1:0]     count
);

  localparam int SW = sat_sum_width(WIDTH);

  logic [SW-1:0] sum;

  always_comb begin
    sum = {1'b0, count} + SW'(inc_val);
  end

  // The carry bit of sum flags overflow; clamp to all-ones in that case.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc_en) begin
      count <= sum[SW-1] ? '1 : sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/eth_phy_10g_link_ctrl.sv
// eth_phy_10g_link_ctrl
// Link bring-up sequencer for the 10G PHY, in the PHY RX clock domain.
// Drives the SERDES RX reset, waits for block lock and a debounced rx_status,
// then raises link_up. Re-sequences on link loss or a PHY reset request and
// keeps saturating diagnostic counters.
// Optional PRBS31 test mode: define ETH_PHY_10G_LINK_CTRL_PRBS_EN.
// Ports:
//   clk, rst                 : PHY RX clock, synchronous active-high reset
//   enable                   : link enable, low forces IDLE
//   phy_rx_block_lock        : PHY block lock
//   phy_rx_high_ber          : PHY high-BER flag
//   phy_rx_status            : PHY RX status
//   phy_serdes_rx_reset_req  : PHY request to reset the SERDES
//   serdes_rx_reset          : transceiver RX reset
//   link_up                  : link usable
//   link_state               : current FSM state
//   link_down_count          : LINK_UP exits (saturating)
//   lock_timeout_count       : WAIT_LOCK timeouts (saturating)
//   PRBS build only: cfg_prbs_mode, phy_rx_error_count, cfg_tx_prbs31_enable,
//   cfg_rx_prbs31_enable, prbs_error_total
module eth_phy_10g_link_ctrl
  import eth_phy_10g_pkg::*;
#(
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 phy_rx_block_lock,
  input  logic                 phy_rx_high_ber,
  input  logic                 phy_rx_status,
  input  logic                 phy_serdes_rx_reset_req,
`ifdef ETH_PHY_10G_LINK_CTRL_PRBS_EN
  input  logic                 cfg_prbs_mode,
  input  logic [6:0]           phy_rx_error_count,
  output logic                 cfg_tx_prbs31_enable,
  output logic                 cfg_rx_prbs31_enable,
  output logic [31:0]          prbs_error_total,
`endif
  output logic                 serdes_rx_reset,
  output logic                 link_up,
  output logic [2:0]           link_state,
  output logic [CNT_WIDTH-1:0] link_down_count,
  output logic [CNT_WIDTH-1:0] lock_timeout_count
);

  localparam int TW = timer_width(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  // Each state runs for (load + 1) cycles because the exit test is timer==0.
  localparam logic [TW-1:0] RST_LOAD    = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LOAD = TW'(STABLE_CYCLES - 1);

  link_state_t   state;
  link_state_t   next_state;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic          lock_to_inc;
  logic          link_down_inc;
  logic          reset_req_ok;

  // Reset requests are honoured everywhere except where the SERDES is already
  // held in reset, and (with PRBS) in the PRBS test state.
  always_comb begin
    reset_req_ok = (state != IDLE) && (state != SERDES_RST);
`ifdef ETH_PHY_10G_LINK_CTRL_PRBS_EN
    if (state == PRBS) reset_req_ok = 1'b0;
`endif
  end

  // Next-state and timer logic. Global overrides (enable, reset request,
  // PRBS entry) come first, then the per-state rules. The timer is reloaded
  // whenever the state changes, whatever caused the change.
  always_comb begin
    next_state  = state;
    timer_next  = timer;
    lock_to_inc = 1'b0;

    if (!enable) begin
      next_state = IDLE;
    end else if (phy_serdes_rx_reset_req && reset_req_ok) begin
      next_state = SERDES_RST;
`ifdef ETH_PHY_10G_LINK_CTRL_PRBS_EN
    end else if (cfg_prbs_mode && (state == WAIT_STABLE || state == LINK_UP)) begin
      next_state = PRBS;
`endif
    end else begin
      case (state)
        IDLE: next_state = SERDES_RST;
        SERDES_RST: begin
          if (timer == '0) next_state = WAIT_LOCK;
          else             timer_next = timer - 1'b1;
        end
        WAIT_LOCK: begin
          if (phy_rx_block_lock) begin
            next_state = WAIT_STABLE;
          end else if (timer == '0) begin
            next_state  = SERDES_RST;
            lock_to_inc = 1'b1;
          end else begin
            timer_next = timer - 1'b1;
          end
        end
        WAIT_STABLE: begin
          if (!phy_rx_block_lock)                       next_state = WAIT_LOCK;
          else if (!phy_rx_status || phy_rx_high_ber)   timer_next = STABLE_LOAD;
          else if (timer == '0)                         next_state = LINK_UP;
          else                                          timer_next = timer - 1'b1;
        end
        LINK_UP: begin
          if (!phy_rx_status) next_state = WAIT_LOCK;
        end
`ifdef ETH_PHY_10G_LINK_CTRL_PRBS_EN
        PRBS: begin
          if (!cfg_prbs_mode) next_state = SERDES_RST;
        end
`endif
        default: next_state = IDLE;
      endcase
    end

    if (next_state != state) begin
      case (next_state)
        SERDES_RST:  timer_next = RST_LOAD;
        WAIT_LOCK:   timer_next = LOCK_LOAD;
        WAIT_STABLE: timer_next = STABLE_LOAD;
        default:     timer_next = '0;
      endcase
    end
  end

  // Any departure from LINK_UP counts as a link-down event.
  assign link_down_inc = (state == LINK_UP) && (next_state != LINK_UP);
  assign link_state    = state;

  // State, timer and registered outputs decoded from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      timer           <= '0;
      serdes_rx_reset <= 1'b1;
      link_up         <= 1'b0;
    end else begin
      state           <= next_state;
      timer           <= timer_next;
      serdes_rx_reset <= (next_state == IDLE) || (next_state == SERDES_RST);
      link_up         <= (next_state == LINK_UP);
    end
  end

  eth_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_link_down_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (1'b0),
    .inc_en  (link_down_inc),
    .inc_val (1'b1),
    .count   (link_down_count)
  );

  eth_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_lock_to_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (1'b0),
    .inc_en  (lock_to_inc),
    .inc_val (1'b1),
    .count   (lock_timeout_count)
  );

`ifdef ETH_PHY_10G_LINK_CTRL_PRBS_EN
  logic prbs_entry;

  assign prbs_entry = (state != PRBS) && (next_state == PRBS);

  // PRBS enables follow the next state, like link_up.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_tx_prbs31_enable <= 1'b0;
      cfg_rx_prbs31_enable <= 1'b0;
    end else begin
      cfg_tx_prbs31_enable <= (next_state == PRBS);
      cfg_rx_prbs31_enable <= (next_state == PRBS);
    end
  end

  // The total restarts on every PRBS entry and accumulates while in PRBS.
  eth_sat_counter #(.WIDTH(32), .INC_WIDTH(7)) u_prbs_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (prbs_entry),
    .inc_en  (state == PRBS),
    .inc_val (phy_rx_error_count),
    .count   (prbs_error_total)
  );
`endif

endmodule

// File: doc/eth_phy_10g_link_ctrl.md
Name: eth_phy_10g_link_ctrl

Overview:
- Link bring-up sequencer for the 10G PHY. Runs in the PHY RX clock domain.
- Owns the SERDES RX reset, and waits for block lock and a debounced good rx_status before declaring link up.
- On link loss or a PHY reset request it re-sequences the link, and it keeps saturating diagnostic counters.
- Sits between the PHY status outputs, the transceiver reset, and the MAC/management link indication.

Parameters:
- RESET_CYCLES, 64: width of the serdes_rx_reset pulse, in clk cycles; minimum 1.
- LOCK_TIMEOUT, 65535: cycles allowed in WAIT_LOCK before re-resetting the SERDES.
- STABLE_CYCLES, 1024: cycles rx_status must stay continuously high before link_up asserts.
- CNT_WIDTH, 16: width of the diagnostic counters.

Ports:
- clk  in  1  PHY RX clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  link enable; low forces IDLE.
- phy_rx_block_lock  in  1  PHY block lock.
- phy_rx_high_ber  in  1  PHY high-BER flag.
- phy_rx_status  in  1  PHY RX status (lock and no high BER).
- phy_serdes_rx_reset_req  in  1  PHY request to reset the SERDES.
- serdes_rx_reset  out  1  reset to the transceiver RX.
- link_up  out  1  link usable.
- link_state  out  3  current FSM state encoding.
- link_down_count  out  CNT_WIDTH  number of LINK_UP exits, saturating.
- lock_timeout_count  out  CNT_WIDTH  number of WAIT_LOCK timeouts, saturating.
- PRBS ports (present only with the macro):
  - cfg_prbs_mode  in  1  request PRBS31 test mode.
  - phy_rx_error_count  in  7  per-cycle PRBS error count from the PHY.
  - cfg_tx_prbs31_enable  out  1  PRBS31 enable to the PHY TX.
  - cfg_rx_prbs31_enable  out  1  PRBS31 enable to the PHY RX.
  - prbs_error_total  out  32  accumulated PRBS errors, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. PHY status inputs are already in the clk domain; the block adds no synchronisers.
- Reset values: state IDLE, serdes_rx_reset=1, link_up=0, all counters 0, PRBS enables 0, timer 0.
- States and link_state encoding: IDLE=0, SERDES_RST=1, WAIT_LOCK=2, WAIT_STABLE=3, LINK_UP=4, PRBS=5.
- Timer: a single shared down-counter, sized by $clog2 of the largest parameter. It is loaded on every state entry.
- Transition priority, evaluated each cycle:
  1. enable=0 → IDLE.
  2. phy_serdes_rx_reset_req=1 while not in IDLE or SERDES_RST → SERDES_RST.
  3. The per-state rule below.
- IDLE:
  - serdes_rx_reset=1.
  - enable=1 → SERDES_RST.
- SERDES_RST:
  - serdes_rx_reset=1 for exactly RESET_CYCLES cycles, then → WAIT_LOCK.
  - A reset request arriving during this state is ignored; the pulse is not extended.
- WAIT_LOCK:
  - serdes_rx_reset=0.
  - block_lock=1 → WAIT_STABLE.
  - Timer expires after LOCK_TIMEOUT cycles → SERDES_RST, and lock_timeout_count increments.
- WAIT_STABLE:
  - rx_status=0 or high_ber=1 reloads the timer.
  - block_lock=0 → WAIT_LOCK (this reloads the lock timeout).
  - STABLE_CYCLES consecutive good cycles → LINK_UP.
- LINK_UP:
  - link_up=1, registered; it asserts the first cycle in LINK_UP.
  - rx_status=0 → WAIT_LOCK, link_up deasserts the next cycle, and link_down_count increments.
  - The same exit-and-count rule applies when LINK_UP is left for any other reason (enable low, reset request).
- Counters saturate at all-ones and do not wrap.
- Latency: link_up asserts no earlier than 1 + RESET_CYCLES + STABLE_CYCLES cycles after enable rises, given a PHY that is already locked.
- Mid-operation rst: every output returns to its reset value on the next edge.

Optional Feature:
- Macro: ETH_PHY_10G_LINK_CTRL_PRBS_EN.
- Defined:
  - The PRBS ports exist.
  - cfg_prbs_mode=1 in WAIT_STABLE or LINK_UP → PRBS. Leaving LINK_UP this way counts as a link-down.
  - In PRBS: both PRBS enables = 1, link_up = 0, and prbs_error_total += phy_rx_error_count each cycle, saturating at 2^32−1.
  - The PRBS state ignores block_lock and reset requests.
  - cfg_prbs_mode=0 → SERDES_RST.
  - prbs_error_total clears on entry to PRBS.
- Undefined: the PRBS ports are absent, state 5 is unreachable, and the design has no PRBS logic.

Decomposition:
- Package eth_phy_10g_pkg holds:
  - the link_state enum (IDLE..PRBS, 3 bits);
  - a sat_inc width rule;
  - the default parameter constants.
- One sub-module, eth_sat_counter: saturating counter with parameterised width, increment value and clear. It is used for the diagnostic counters and the PRBS total.
- The FSM and the timer stay in the top module.

Test Plan:
- Bring-up: enable=1, block_lock rises 10 cycles after reset release, status good (test parameters RESET_CYCLES=4, STABLE_CYCLES=8) → serdes_rx_reset high for exactly 4 cycles, link_up=1 exactly 8 cycles after WAIT_STABLE entry, link_state=4.
- Lock timeout: LOCK_TIMEOUT=20, block_lock never rises → re-reset every 4+20 cycles, lock_timeout_count=3 after the third expiry; a saturation test with CNT_WIDTH=2 holds the count at 3.
- Debounce: status drops for 1 cycle at good-cycle 5 of 8 in WAIT_STABLE → timer restarts, link_up delayed to 8 cycles after the glitch.
- Link loss: status drops in LINK_UP → link_up=0 the next cycle, link_down_count=1, state=2; a later reset request → SERDES_RST.
- Priority: enable=0 and reset request asserted in the same cycle in LINK_UP → state IDLE, serdes_rx_reset=1, link_down_count incremented once; a synchronous rst mid-SERDES_RST returns all outputs to reset values.
- PRBS (macro defined): cfg_prbs_mode=1 in LINK_UP, phy_rx_error_count=100 for 5 cycles → enables=1, total=500; releasing cfg_prbs_mode → SERDES_RST, enables=0.
